uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter. Generalised successor to the fixed 32-bit, 4-byte, 64-deep MMIO UART path.
- Accepts CPU word writes into a synchronous FIFO of parametrised depth. Splits each word into a software-selected number of bytes in a selectable order, and serialises each byte as an 8-bit frame with optional parity and 1 or 2 stop bits.
- Runtime-programmable baud divisor, readable status and an empty interrupt.
- Sits on the data-memory bus beside other MMIO peripherals; single clock domain.

Parameters:
- ADDR_BASE, 32'h0000_7000, base of 4-register window: +0 TXDATA(W), +4 STATUS(R/W1C), +8 DIVISOR(R/W), +C CTRL(R/W).
- FIFO_DEPTH, 16, word entries; power of 2, range 2..256.
- DIV_RESET, 867, DIVISOR reset value; bit period = DIVISOR+1 clocks.
- MSB_FIRST_RESET, 1, CTRL.msb_first reset value.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- we  in  1  bus write strobe.
- address  in  32  bus byte address.
- dataIn  in  32  bus write data.
- readData  out  32  combinational read data for address. 0 outside the window, and 0 for TXDATA.
- serial  out  1  UART TX line; idle high.
- irq  out  1  high when CTRL.irq_en and FIFO empty and engine idle.

Behaviour:
- Reset values:
  - serial=1, irq=0, FIFO empty (level 0), overflow=0.
  - DIVISOR=DIV_RESET.
  - CTRL: bpw=3 (4 bytes), parity_en=0, parity_odd=0, stop2=0, msb_first=MSB_FIRST_RESET, irq_en=0.
  - State=IDLE.
- CTRL bits:
  - [1:0] bpw: bytes per word minus 1.
  - [2] parity_en.
  - [3] parity_odd (0=even).
  - [4] stop2.
  - [5] msb_first.
  - [6] irq_en.
  - [31] fifo_clear: write-only, self-clearing, reads 0.
- STATUS bits:
  - [0] empty.
  - [1] full.
  - [2] busy (state!=IDLE).
  - [3] overflow: sticky; cleared by writing 1 to bit 3.
  - [15:8] level.
  - Other bits read 0.
- DIVISOR:
  - 16 bits; upper bits read 0.
  - Latched into the bit-timer at the start of each frame (START entry). A mid-frame write affects only the next frame.
- TXDATA write (we && address==ADDR_BASE):
  - Pushes dataIn at that edge.
  - If full before the edge: word dropped, overflow set; this holds even if a pop occurs the same edge.
  - Simultaneous push and pop (not full): level unchanged.
- FSM states: IDLE, LOAD, START, DATA, PARITY, STOP.
  - IDLE: serial=1. If FIFO non-empty -> LOAD.
  - LOAD: 1 clock, serial=1. Pop word into holding register; byte index=0; CTRL snapshot for the whole word. -> START.
  - START: serial=0 for DIVISOR+1 clocks -> DATA.
  - DATA: 8 bits, LSB first, DIVISOR+1 clocks each. -> PARITY if parity_en, else STOP.
  - PARITY: 1 bit, even = XOR of data bits, odd = its inverse. -> STOP.
  - STOP: serial=1 for 1 bit (2 if stop2).
    - If more bytes remain in the word: -> START with no gap.
    - Else if FIFO non-empty: -> LOAD.
    - Else: -> IDLE.
- Byte selection: the low bpw+1 bytes of the word are sent.
  - msb_first=1: highest of those bytes first (bpw=3: [31:24],[23:16],[15:8],[7:0]).
  - msb_first=0: [7:0] first.
- Latency: write at edge k with engine IDLE -> LOAD at k+1 -> serial falls at edge k+2.
- fifo_clear:
  - FIFO emptied at that edge; overflow unchanged.
  - The in-flight frame completes. Remaining bytes of the current word are abandoned; STOP then goes to IDLE.
  - A TXDATA push in the same cycle is discarded.
- Level arithmetic is width clog2(FIFO_DEPTH)+1, saturating at FIFO_DEPTH via the full check. Pointers wrap modulo FIFO_DEPTH.
- reset_n low mid-frame: everything returns to reset values immediately; serial=1 asynchronously.

Test Plan:
- Reset, DIVISOR=3, CTRL=0x23 (4 bytes, MSB first), write 0x4142_4344 -> 4 frames 0x41,0x42,0x43,0x44. Each frame 10 bits x 4 clocks, back-to-back. First start bit 2 clocks after the write. STATUS.busy=1 throughout, then 0x0000_0001 after.
- CTRL=0x01 (2 bytes, LSB first), parity_en|parity_odd set, write 0x0000_A50F -> 0x0F then 0xA5, each 11 bits. Parity bits 1 and 1.
- DIVISOR=0, write FIFO_DEPTH+1 words while busy -> level=16, full=1, overflow=1, extra word never sent. Write 0x8 to STATUS -> overflow=0.
- During byte 2 of a 4-byte word with 3 words queued, write CTRL[31] -> current frame finishes, then serial idles. STATUS=0x0000_0001.
- irq_en=1, one word sent -> irq rises 1 clock after last stop bit ends. A new write drops irq the next clock.
- reset_n pulsed low mid DATA bit -> serial=1 immediately, all registers at reset values, no further frames.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU words go through a FIFO, are split into
// 1..4 bytes and serialised as 8-bit frames with optional parity and 1/2 stop bits.
module uart_tx_mmio #(
  parameter logic [31:0] ADDR_BASE       = 32'h0000_7000,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [15:0] DIV_RESET       = 16'd867,
  parameter logic        MSB_FIRST_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] readData,
  output logic        serial,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  function automatic logic parity_f(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t        state_r, state_next_s;
  logic [31:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          overflow_r;
  logic [15:0]   divisor_r, div_lat_r, cnt_r;
  logic [1:0]    bpw_r, snap_bpw_r, byte_idx_r;
  logic          par_en_r, par_odd_r, stop2_r, msb_r, irq_en_r;
  logic          snap_par_en_r, snap_par_odd_r, snap_stop2_r, snap_msb_r;
  logic [31:0]   hold_r;
  logic [2:0]    bit_idx_r, bit_idx_next_s;
  logic          stop_idx_r, abandon_r, serial_r, irq_r, serial_next_s;

  logic sel_tx_s, sel_st_s, sel_div_s, sel_ctrl_s;
  logic push_req_s, push_ok_s, pop_s, clear_s, full_s, empty_s;
  logic bit_done_s, last_byte_s, stop_last_s;
  logic [1:0]  byte_sel_s;
  logic [31:0] shifted_s;
  logic [7:0]  cur_byte_s;
  logic [8:0]  level9_s;

  assign sel_tx_s   = (address == ADDR_BASE);
  assign sel_st_s   = (address == ADDR_BASE + 32'd4);
  assign sel_div_s  = (address == ADDR_BASE + 32'd8);
  assign sel_ctrl_s = (address == ADDR_BASE + 32'd12);

  assign full_s     = (level_r == LW'(FIFO_DEPTH));
  assign empty_s    = (level_r == {LW{1'b0}});
  assign push_req_s = we && sel_tx_s;
  assign clear_s    = we && sel_ctrl_s && dataIn[31];
  assign push_ok_s  = push_req_s && !full_s && !clear_s;
  assign pop_s      = (state_r == S_LOAD) && !empty_s;

  assign bit_done_s  = (cnt_r == 16'd0);
  assign last_byte_s = (byte_idx_r == snap_bpw_r);
  assign stop_last_s = (stop_idx_r == snap_stop2_r);
  assign byte_sel_s  = snap_msb_r ? (snap_bpw_r - byte_idx_r) : byte_idx_r;
  assign shifted_s   = hold_r >> {byte_sel_s, 3'b000};
  assign cur_byte_s  = shifted_s[7:0];
  assign level9_s    = 9'(level_r);

  assign serial = serial_r;
  assign irq    = irq_r;

  // Word storage; written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok_s) fifo_mem_r[wr_ptr_r] <= dataIn;
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (clear_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Software-visible configuration and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor_r  <= DIV_RESET;
      bpw_r      <= 2'd3;
      par_en_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      stop2_r    <= 1'b0;
      msb_r      <= MSB_FIRST_RESET;
      irq_en_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (we && sel_div_s) divisor_r <= dataIn[15:0];
      if (we && sel_ctrl_s) begin
        bpw_r     <= dataIn[1:0];
        par_en_r  <= dataIn[2];
        par_odd_r <= dataIn[3];
        stop2_r   <= dataIn[4];
        msb_r     <= dataIn[5];
        irq_en_r  <= dataIn[6];
      end
      if (push_req_s && full_s)                overflow_r <= 1'b1;
      else if (we && sel_st_s && dataIn[3])    overflow_r <= 1'b0;
    end
  end

  // Next state plus the line level that state will drive
  always_comb begin
    state_next_s   = state_r;
    bit_idx_next_s = bit_idx_r;
    serial_next_s  = 1'b1;
    case (state_r)
      S_IDLE: begin
        if (!empty_s && !clear_s) state_next_s = S_LOAD;
        else                      state_next_s = S_IDLE;
      end
      S_LOAD: begin
        if (!empty_s) state_next_s = S_START;
        else          state_next_s = S_IDLE;
      end
      S_START: begin
        bit_idx_next_s = 3'd0;
        if (bit_done_s) state_next_s = S_DATA;
        else            state_next_s = S_START;
      end
      S_DATA: begin
        if (bit_done_s) begin
          bit_idx_next_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) state_next_s = snap_par_en_r ? S_PARITY : S_STOP;
          else                   state_next_s = S_DATA;
        end else begin
          state_next_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_done_s) state_next_s = S_STOP;
        else            state_next_s = S_PARITY;
      end
      S_STOP: begin
        if (bit_done_s && stop_last_s) begin
          if (!last_byte_s && !abandon_r && !clear_s) state_next_s = S_START;
          else if (!empty_s && !clear_s)              state_next_s = S_LOAD;
          else                                        state_next_s = S_IDLE;
        end else begin
          state_next_s = S_STOP;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
    case (state_next_s)
      S_START:  serial_next_s = 1'b0;
      S_DATA:   serial_next_s = cur_byte_s[bit_idx_next_s];
      S_PARITY: serial_next_s = parity_f(cur_byte_s, snap_par_odd_r);
      default:  serial_next_s = 1'b1;
    endcase
  end

  // Transmit engine registers, bit timer and registered line/irq outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= S_IDLE;
      serial_r       <= 1'b1;
      irq_r          <= 1'b0;
      bit_idx_r      <= 3'd0;
      cnt_r          <= 16'd0;
      div_lat_r      <= 16'd0;
      stop_idx_r     <= 1'b0;
      byte_idx_r     <= 2'd0;
      hold_r         <= 32'd0;
      abandon_r      <= 1'b0;
      snap_bpw_r     <= 2'd0;
      snap_par_en_r  <= 1'b0;
      snap_par_odd_r <= 1'b0;
      snap_stop2_r   <= 1'b0;
      snap_msb_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      serial_r  <= serial_next_s;
      bit_idx_r <= bit_idx_next_s;
      irq_r     <= irq_en_r && empty_s && (state_r == S_IDLE);
      // The divisor is sampled once per frame so mid-frame writes wait a frame
      if (state_next_s == S_START && state_r != S_START) begin
        cnt_r     <= divisor_r;
        div_lat_r <= divisor_r;
      end else if (bit_done_s) begin
        cnt_r <= div_lat_r;
      end else begin
        cnt_r <= cnt_r - 16'd1;
      end
      if (state_r != S_STOP) stop_idx_r <= 1'b0;
      else if (bit_done_s)   stop_idx_r <= stop_idx_r + 1'b1;
      if (state_r == S_LOAD)                                byte_idx_r <= 2'd0;
      else if (state_r == S_STOP && state_next_s == S_START) byte_idx_r <= byte_idx_r + 2'd1;
      if (pop_s) begin
        hold_r         <= fifo_mem_r[rd_ptr_r];
        snap_bpw_r     <= bpw_r;
        snap_par_en_r  <= par_en_r;
        snap_par_odd_r <= par_odd_r;
        snap_stop2_r   <= stop2_r;
        snap_msb_r     <= msb_r;
      end
      if (clear_s)                abandon_r <= 1'b1;
      else if (state_r == S_LOAD) abandon_r <= 1'b0;
    end
  end

  // Register readback; TXDATA and addresses outside the window read zero
  always_comb begin
    readData = 32'd0;
    if (sel_st_s) begin
      readData = {16'd0, level9_s[7:0], 4'd0, overflow_r, (state_r != S_IDLE), full_s, empty_s};
    end else if (sel_div_s) begin
      readData = {16'd0, divisor_r};
    end else if (sel_ctrl_s) begin
      readData = {25'd0, irq_en_r, msb_r, stop2_r, par_odd_r, par_en_r, bpw_r};
    end else begin
      readData = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: expected serial waveforms are built per clock from the
// frame format (start, 8 data LSB first, optional parity, stop bits) and compared live.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_7000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] address = 32'h0000_7004;
  logic [31:0] dataIn = 32'd0;
  logic [31:0] readData;
  logic        serial;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];

  uart_tx_mmio #(
    .ADDR_BASE(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd867), .MSB_FIRST_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .address(address), .dataIn(dataIn),
    .readData(readData), .serial(serial), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endfunction

  // One sample per clock of every frame for the low bpw+1 bytes of w
  function automatic void add_word(input logic [31:0] w, input int bpw, input bit pen,
                                   input bit podd, input bit stop2, input bit msb, input int div);
    for (int j = 0; j <= bpw; j++) begin
      int k;
      logic [7:0] b;
      k = msb ? (bpw - j) : j;
      b = w[8*k +: 8];
      for (int r = 0; r <= div; r++) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int r = 0; r <= div; r++) exp_q.push_back(b[i]);
      if (pen)
        for (int r = 0; r <= div; r++) exp_q.push_back((^b) ^ podd);
      for (int r = 0; r < (stop2 ? 2 : 1) * (div + 1); r++) exp_q.push_back(1'b1);
    end
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; address = a; dataIn = d;
    @(posedge clk);
    #1;
    we = 1'b0; address = BASE + 32'd4;
  endtask

  task automatic test_reset;
    logic [31:0] addrs [5];
    logic [31:0] exps  [5];
    addrs = '{BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE, BASE + 32'd16};
    exps  = '{32'h0000_0001, 32'd867, 32'h0000_0023, 32'd0, 32'd0};
    @(negedge clk);
    n_cmp++; if (serial !== 1'b1) begin n_bad++; $display("FAIL reset_serial got %b want 1", serial); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
    for (int i = 0; i < 5; i++) begin
      address = addrs[i]; #1;
      n_cmp++;
      if (readData !== exps[i]) begin
        n_bad++; $display("FAIL reset_read addr %h got %h want %h", addrs[i], readData, exps[i]);
      end
    end
    address = BASE + 32'd4;
  endtask

  task automatic test_basic_frames;
    int L;
    bus_write(BASE + 32'd8, 32'd3);
    bus_write(BASE + 32'd12, 32'h23);
    exp_q.delete(); add_idle(2); add_word(32'h4142_4344, 3, 0, 0, 0, 1, 3);
    L = exp_q.size(); add_idle(4);
    bus_write(BASE, 32'h4142_4344);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (serial !== exp_q[i]) begin n_bad++; $display("FAIL basic_serial idx %0d got %b want %b", i, serial, exp_q[i]); end
      n_cmp++;
      if (readData[2] !== (i >= 1 && i < L)) begin
        n_bad++; $display("FAIL basic_busy idx %0d got %b want %b", i, readData[2], (i >= 1 && i < L));
      end
    end
    n_cmp++; if (readData !== 32'h0000_0001) begin n_bad++; $display("FAIL basic_status got %h want 00000001", readData); end
  endtask

  task automatic test_parity;
    bus_write(BASE + 32'd12, 32'h0D);
    exp_q.delete(); add_idle(2); add_word(32'h0000_A50F, 1, 1, 1, 0, 0, 3); add_idle(4);
    bus_write(BASE, 32'h0000_A50F);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (serial !== exp_q[i]) begin n_bad++; $display("FAIL parity_serial idx %0d got %b want %b", i, serial, exp_q[i]); end
      if (i == 38 || i == 82) begin
        n_cmp++;
        if (serial !== 1'b1) begin n_bad++; $display("FAIL parity_bit idx %0d got %b want 1", i, serial); end
      end
    end
    n_cmp++; if (readData !== 32'h0000_0001) begin n_bad++; $display("FAIL parity_status got %h want 00000001", readData); end
  endtask

  task automatic test_random_words;
    for (int it = 0; it < 4; it++) begin
      int div, bpw;
      bit pen, podd, stop2, msb;
      logic [31:0] w [3];
      div = $urandom_range(0, 2); bpw = $urandom_range(0, 3);
      pen = 1'($urandom); podd = 1'($urandom); stop2 = 1'($urandom); msb = 1'($urandom);
      for (int i = 0; i < 3; i++) w[i] = $urandom;
      bus_write(BASE + 32'd8, 32'(div));
      bus_write(BASE + 32'd12, {25'd0, 1'b0, msb, stop2, podd, pen, 2'(bpw)});
      exp_q.delete(); add_idle(2);
      for (int i = 0; i < 3; i++) begin
        if (i > 0) add_idle(1);
        add_word(w[i], bpw, pen, podd, stop2, msb, div);
      end
      add_idle(10);
      bus_write(BASE, w[0]);
      fork
        begin
          for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (serial !== exp_q[i]) begin
              n_bad++; $display("FAIL random_serial it %0d idx %0d got %b want %b", it, i, serial, exp_q[i]);
            end
          end
        end
        begin
          bus_write(BASE, w[1]);
          bus_write(BASE, w[2]);
        end
      join
    end
  endtask

  task automatic test_overflow;
    logic [31:0] w [18];
    for (int i = 0; i < 18; i++) w[i] = $urandom;
    bus_write(BASE + 32'd8, 32'd0);
    bus_write(BASE + 32'd12, 32'h23);
    exp_q.delete(); add_idle(2); add_word(w[0], 3, 0, 0, 0, 1, 0);
    for (int i = 1; i <= DEPTH; i++) begin add_idle(1); add_word(w[i], 3, 0, 0, 0, 1, 0); end
    add_idle(20);
    bus_write(BASE, w[0]);
    fork
      begin
        for (int i = 0; i < exp_q.size(); i++) begin
          @(negedge clk); #1;
          n_cmp++;
          if (serial !== exp_q[i]) begin n_bad++; $display("FAIL ovf_serial idx %0d got %b want %b", i, serial, exp_q[i]); end
        end
      end
      begin
        for (int i = 1; i <= DEPTH + 1; i++) bus_write(BASE, w[i]);
        @(negedge clk); address = BASE + 32'd4; #1;
        n_cmp++; if (readData !== 32'h0000_100E) begin n_bad++; $display("FAIL ovf_status_full got %h want 0000100e", readData); end
        bus_write(BASE + 32'd4, 32'h8);
        @(negedge clk); address = BASE + 32'd4; #1;
        n_cmp++; if (readData !== 32'h0000_1006) begin n_bad++; $display("FAIL ovf_w1c got %h want 00001006", readData); end
      end
    join
    address = BASE + 32'd4; #1;
    n_cmp++; if (readData !== 32'h0000_0001) begin n_bad++; $display("FAIL ovf_final_status got %h want 00000001", readData); end
  endtask

  task automatic test_fifo_clear;
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    bus_write(BASE + 32'd8, 32'd1);
    bus_write(BASE + 32'd12, 32'h23);
    exp_q.delete(); add_idle(2); add_word(w[0] >> 8, 2, 0, 0, 0, 1, 1); add_idle(40);
    bus_write(BASE, w[0]);
    fork
      begin
        for (int i = 0; i < exp_q.size(); i++) begin
          @(negedge clk); #1;
          n_cmp++;
          if (serial !== exp_q[i]) begin n_bad++; $display("FAIL clear_serial idx %0d got %b want %b", i, serial, exp_q[i]); end
        end
      end
      begin
        for (int i = 1; i < 4; i++) bus_write(BASE, w[i]);
        repeat (45) @(negedge clk);
        bus_write(BASE + 32'd12, 32'h8000_0023);
      end
    join
    address = BASE + 32'd4; #1;
    n_cmp++; if (readData !== 32'h0000_0001) begin n_bad++; $display("FAIL clear_status got %h want 00000001", readData); end
    address = BASE + 32'd12; #1;
    n_cmp++; if (readData !== 32'h0000_0023) begin n_bad++; $display("FAIL clear_ctrl got %h want 00000023", readData); end
    address = BASE + 32'd4;
  endtask

  task automatic test_irq;
    int L;
    logic [31:0] w;
    w = $urandom;
    bus_write(BASE + 32'd8, 32'd0);
    bus_write(BASE + 32'd12, 32'h63);
    exp_q.delete(); add_idle(2); add_word(w, 3, 0, 0, 0, 1, 0);
    L = exp_q.size(); add_idle(4);
    bus_write(BASE, w);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (serial !== exp_q[i]) begin n_bad++; $display("FAIL irq_serial idx %0d got %b want %b", i, serial, exp_q[i]); end
      n_cmp++;
      if (irq !== (i == 0 || i > L)) begin n_bad++; $display("FAIL irq_level idx %0d got %b want %b", i, irq, (i == 0 || i > L)); end
    end
    bus_write(BASE, $urandom);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_after_write got %b want 1", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_drop got %b want 0", irq); end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    bus_write(BASE + 32'd8, 32'd3);
    bus_write(BASE + 32'd12, 32'h23);
    bus_write(BASE, 32'h4142_4344);
    repeat (12) @(negedge clk);
    n_cmp++; if (serial !== 1'b0) begin n_bad++; $display("FAIL rst_pre_serial got %b want 0", serial); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (serial !== 1'b1) begin n_bad++; $display("FAIL rst_async_serial got %b want 1", serial); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b want 0", irq); end
    address = BASE + 32'd4; #1;
    n_cmp++; if (readData !== 32'h0000_0001) begin n_bad++; $display("FAIL rst_status got %h want 00000001", readData); end
    address = BASE + 32'd8; #1;
    n_cmp++; if (readData !== 32'd867) begin n_bad++; $display("FAIL rst_divisor got %h want 00000363", readData); end
    address = BASE + 32'd12; #1;
    n_cmp++; if (readData !== 32'h0000_0023) begin n_bad++; $display("FAIL rst_ctrl got %h want 00000023", readData); end
    address = BASE + 32'd4;
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (serial !== 1'b1) begin n_bad++; $display("FAIL rst_idle_serial idx %0d got %b want 1", i, serial); end
    end
    n_cmp++; if (readData !== 32'h0000_0001) begin n_bad++; $display("FAIL rst_final_status got %h want 00000001", readData); end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_basic_frames();
    test_parity();
    test_random_words();
    test_overflow();
    test_fifo_clear();
    test_irq();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
